// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: turns accepted 40-bit UART command words into capture
// configuration registers, control pulses and the armed/idle capture state.
module sump_cmd_decoder #(
    parameter int STAGES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  execute,
    input  logic [39:0]           cmd,
    input  logic                  capture_done,
    output logic                  soft_reset,
    output logic                  arm,
    output logic                  meta_req,
    output logic                  armed,
    output logic [23:0]           divider,
    output logic [15:0]           read_count,
    output logic [15:0]           delay_count,
    output logic [31:0]           flags,
    output logic [32*STAGES-1:0]  trig_mask,
    output logic [32*STAGES-1:0]  trig_value,
    output logic [32*STAGES-1:0]  trig_cfg,
    output logic                  cfg_locked,
    output logic                  unknown
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic execute_q, execute_d;
    logic soft_reset_q, soft_reset_d;
    logic arm_q, arm_d;
    logic meta_req_q, meta_req_d;
    logic cfg_locked_q, cfg_locked_d;
    logic unknown_q, unknown_d;

    logic [23:0] divider_q, divider_d;
    logic [15:0] read_count_q, read_count_d;
    logic [15:0] delay_count_q, delay_count_d;
    logic [31:0] flags_q, flags_d;

    logic [32*STAGES-1:0] trig_mask_q, trig_mask_d;
    logic [32*STAGES-1:0] trig_value_q, trig_value_d;
    logic [32*STAGES-1:0] trig_cfg_q, trig_cfg_d;

    logic        accept;
    logic        is_armed;
    logic        stage_ok;
    logic [7:0]  opcode;
    logic [31:0] opdata;

    assign opcode   = cmd[7:0];
    assign opdata   = cmd[39:8];
    assign accept   = execute & ~execute_q;
    assign is_armed = (state_q == ST_ARMED);

    // Trigger opcodes encode the stage in bits [3:2]; only existing stages are writable.
    always_comb begin
        stage_ok = 1'b0;
        for (int n = 0; n < STAGES; n++) begin
            if (opcode[3:2] == 2'(n)) begin
                stage_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        execute_d     = execute;
        soft_reset_d  = 1'b0;
        arm_d         = 1'b0;
        meta_req_d    = 1'b0;
        cfg_locked_d  = 1'b0;
        unknown_d     = 1'b0;
        divider_d     = divider_q;
        read_count_d  = read_count_q;
        delay_count_d = delay_count_q;
        flags_d       = flags_q;
        trig_mask_d   = trig_mask_q;
        trig_value_d  = trig_value_q;
        trig_cfg_d    = trig_cfg_q;

        if (is_armed && capture_done) begin
            state_d = ST_IDLE;
        end

        // The lock check uses the current armed state, so a write racing capture_done is rejected.
        if (accept) begin
            case (opcode)
                8'h00: begin
                    soft_reset_d = 1'b1;
                    state_d      = ST_IDLE;
                end
                8'h01: begin
                    if (!is_armed) begin
                        arm_d   = 1'b1;
                        state_d = ST_ARMED;
                    end
                end
                8'h02, 8'h11, 8'h13: begin
                end
                8'h04: begin
                    meta_req_d = 1'b1;
                end
                8'h80: begin
                    if (is_armed) cfg_locked_d = 1'b1;
                    else          divider_d    = opdata[23:0];
                end
                8'h81: begin
                    if (is_armed) begin
                        cfg_locked_d = 1'b1;
                    end else begin
                        read_count_d  = opdata[15:0];
                        delay_count_d = opdata[31:16];
                    end
                end
                8'h82: begin
                    if (is_armed) cfg_locked_d = 1'b1;
                    else          flags_d      = opdata;
                end
                default: begin
                    if (opcode[7:4] != 4'hC) begin
                        unknown_d = 1'b1;
                    end else if (opcode[1:0] == 2'b11) begin
                        unknown_d = 1'b0;
                    end else if (!stage_ok) begin
                        unknown_d = 1'b1;
                    end else if (is_armed) begin
                        cfg_locked_d = 1'b1;
                    end else begin
                        for (int n = 0; n < STAGES; n++) begin
                            if (opcode[3:2] == 2'(n)) begin
                                case (opcode[1:0])
                                    2'b00:   trig_mask_d[32*n +: 32]  = opdata;
                                    2'b01:   trig_value_d[32*n +: 32] = opdata;
                                    default: trig_cfg_d[32*n +: 32]   = opdata;
                                endcase
                            end
                        end
                    end
                end
            endcase
        end
    end

    // execute_q resets high so an execute held across reset release is not seen as an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            execute_q     <= 1'b1;
            soft_reset_q  <= 1'b0;
            arm_q         <= 1'b0;
            meta_req_q    <= 1'b0;
            cfg_locked_q  <= 1'b0;
            unknown_q     <= 1'b0;
            divider_q     <= '0;
            read_count_q  <= '0;
            delay_count_q <= '0;
            flags_q       <= '0;
            trig_mask_q   <= '0;
            trig_value_q  <= '0;
            trig_cfg_q    <= '0;
        end else begin
            state_q       <= state_d;
            execute_q     <= execute_d;
            soft_reset_q  <= soft_reset_d;
            arm_q         <= arm_d;
            meta_req_q    <= meta_req_d;
            cfg_locked_q  <= cfg_locked_d;
            unknown_q     <= unknown_d;
            divider_q     <= divider_d;
            read_count_q  <= read_count_d;
            delay_count_q <= delay_count_d;
            flags_q       <= flags_d;
            trig_mask_q   <= trig_mask_d;
            trig_value_q  <= trig_value_d;
            trig_cfg_q    <= trig_cfg_d;
        end
    end

    assign soft_reset  = soft_reset_q;
    assign arm         = arm_q;
    assign meta_req    = meta_req_q;
    assign armed       = is_armed;
    assign cfg_locked  = cfg_locked_q;
    assign unknown     = unknown_q;
    assign divider     = divider_q;
    assign read_count  = read_count_q;
    assign delay_count = delay_count_q;
    assign flags       = flags_q;
    assign trig_mask   = trig_mask_q;
    assign trig_value  = trig_value_q;
    assign trig_cfg    = trig_cfg_q;

endmodule

// File: doc/sump_cmd_decoder.md
Name: sump_cmd_decoder

Overview:
Consumes the 40-bit command word and execute strobe produced by the UART receive wrapper, and decodes SUMP opcodes into the capture core's configuration registers and control pulses. Sits directly downstream of the uart block and upstream of the sampler, trigger and controller stages. It tracks an armed/idle capture state and locks configuration while a capture runs.

Parameters:
STAGES, 4, number of trigger stages. Legal range 1..4. Each stage has a 32-bit mask, value and config register.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
execute  in  1  command valid; may stay high for several cycles
cmd  in  40  {opdata[31:0], opcode[7:0]}
capture_done  in  1  one-cycle pulse from controller: capture finished
soft_reset  out  1  one-cycle pulse, opcode 0x00
arm  out  1  one-cycle pulse, opcode 0x01 accepted
meta_req  out  1  one-cycle pulse, opcode 0x04
armed  out  1  level: capture in progress
divider  out  24  sample divider, opcode 0x80, opdata[23:0]
read_count  out  16  opcode 0x81, opdata[15:0]
delay_count  out  16  opcode 0x81, opdata[31:16]
flags  out  32  opcode 0x82, opdata[31:0]
trig_mask  out  32*STAGES  stage n occupies bits [32n+31:32n]
trig_value  out  32*STAGES  same packing
trig_cfg  out  32*STAGES  same packing
cfg_locked  out  1  one-cycle pulse: config write rejected because armed
unknown  out  1  one-cycle pulse: unrecognised opcode

Behaviour:
- Accept on rising edge only: accept = execute & ~execute_q, where execute_q is registered execute.
- execute_q resets to 1. An execute held high through reset release is not accepted. A command needs execute to go low then high.
- Latency: every register update, pulse and armed change occurs at the clock edge following the accept cycle. Pulses are exactly 1 cycle.
- Reset clears all registers, pulses, armed and trig regs to 0.
- Opcode map (acted on only when accepted):
  - 0x00: soft_reset=1; armed cleared. Config is kept.
  - 0x01: if not armed: arm=1 and armed set. If already armed: ignored, no pulse.
  - 0x02, 0x11, 0x13: handled by the uart block; silently ignored here, no unknown pulse.
  - 0x04: meta_req=1.
  - 0x80, 0x81, 0x82: write divider, counts or flags.
  - 0xC0+4n: mask[n]. 0xC1+4n: value[n]. 0xC2+4n: cfg[n]. Applies for n < STAGES.
  - 0xC3+4n: reserved; ignored without an unknown pulse.
  - Trigger opcodes for n >= STAGES, and every other opcode: unknown=1, no state change.
- Config lock: while armed=1, opcodes 0x80, 0x81, 0x82 and 0xC0–0xCF (in-range trigger writes) do not modify state and produce cfg_locked=1.
- armed state machine, two states:
  - IDLE -> ARMED on accepted 0x01.
  - ARMED -> IDLE on capture_done or accepted 0x00.
- Simultaneous events:
  - capture_done in the same cycle as an accepted 0x01 while IDLE: arm wins; armed=1, arm pulses.
  - capture_done in the same cycle as an accepted config write while ARMED: lock evaluated on the current armed=1, so the write is rejected.
  - capture_done while IDLE: no effect.
- Only opdata bits listed above are stored. Upper divider bits [31:24] are discarded.

Test Plan:
1. Reset, then cmd=0x00_12_34_56_80 with execute held high for 3 cycles -> divider=0x123456 one cycle after the rising edge. A single write occurs; no further change while execute stays high.
2. Write 0xC4 with opdata 0xFFFF0000, then 0xC5 with 0xAAAA0000 -> trig_mask[63:32]=0xFFFF0000, trig_value[63:32]=0xAAAA0000; stage 0 and stages 2–3 remain 0.
3. Send 0x01 -> arm pulse and armed=1. Then send 0x81 with opdata 0x00100020 -> cfg_locked pulse; read_count and delay_count stay 0. Pulse capture_done -> armed=0. Resend 0x81 -> read_count=0x0020, delay_count=0x0010.
4. capture_done asserted in the accept cycle of 0x01 while IDLE -> armed=1, arm pulses once. A second 0x01 while armed -> no pulse.
5. Send opcodes 0x02, 0x11, 0x13 -> no outputs change. Send 0x55 -> unknown pulse. With STAGES=2, send 0xC8 -> unknown pulse and trig_mask unchanged.
6. Hold execute high across reset deassert -> nothing accepted. Assert reset after config writes -> all outputs read 0. Send 0x00 while armed -> soft_reset pulse, armed=0, divider kept.
